i2c_apb_sequencer: RTL and testbench

- APB master that drives the APB-to-I2C bridge's register file, so one local request performs a complete I2C master write without CPU involvement.
- Sequence per request: program prescale, program slave address, write the first TX byte, issue the command, stream the remaining bytes with FIFO-full back-pressure, then poll until the bus is idle.
- Sits between a local requester (DMA/sensor engine) and the bridge's APB slave port.

---
 rtl/i2c_apb_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_apb_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_apb_sequencer.sv
// APB master that runs a complete I2C master write through the APB-to-I2C
// bridge: prescale, slave address, first byte, command, remaining bytes with
// FIFO-full back-pressure, then poll until the I2C bus goes idle.
module i2c_apb_sequencer #(
  parameter logic [7:0]  ADDR_PRESCALE  = 8'd1,
  parameter logic [7:0]  ADDR_SLAVE     = 8'd2,
  parameter logic [7:0]  ADDR_STATUS    = 8'd3,
  parameter logic [7:0]  ADDR_TX        = 8'd4,
  parameter logic [7:0]  ADDR_CMD       = 8'd6,
  parameter logic [7:0]  CMD_WRITE      = 8'b10010000,
  parameter int unsigned STAT_FULL_BIT  = 6,
  parameter int unsigned STAT_BUSY_BIT  = 5,
  parameter int unsigned PREADY_TIMEOUT = 64
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       req_start,
  input  logic [7:0] req_prescale,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic       PSELx,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] bytes_sent
);

  localparam int unsigned TO_W  = $clog2(PREADY_TIMEOUT + 1);
  localparam int unsigned GAP_W = 2;
  // Four idle cycles before a status re-read (counter runs 3..0).
  localparam logic [GAP_W-1:0] RETRY_GAP = GAP_W'(3);

  typedef enum logic [3:0] {
    IDLE, W_PRE, W_SADDR, FETCH, RD_STAT, W_TX, W_CMD, POLL_BUSY, FINISH
  } state_t;

  // Sub-phase of an APB state: idle gap, SETUP, ACCESS.
  typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_t;

  state_t            state, state_nxt;
  phase_t            phase, phase_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic [7:0]        lat_pre, lat_addr, lat_len, lat_data;
  logic [7:0]        sent_inc;
  logic              in_apb, acc_done, abort, accept, reject, hs;
  logic              psel_nxt, penable_nxt, pwrite_nxt, wr_ready_nxt;
  logic              busy_nxt, done_nxt, err_nxt;
  logic [7:0]        paddr_nxt, pwdata_nxt;

  function automatic logic is_apb_state(state_t s);
    return (s == W_PRE) || (s == W_SADDR) || (s == RD_STAT) ||
           (s == W_TX)  || (s == W_CMD)   || (s == POLL_BUSY);
  endfunction

  assign sent_inc = bytes_sent + 8'd1;
  assign in_apb   = is_apb_state(state);

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      phase   <= PH_GAP;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  // Next-state: sequencing between register accesses and APB sub-phases
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    gap_nxt   = gap_cnt;
    acc_done  = in_apb && (phase == PH_ACCESS) && PREADY;
    abort     = in_apb && (phase == PH_ACCESS) && !PREADY &&
                (to_cnt == TO_W'(PREADY_TIMEOUT - 1));
    accept    = (state == IDLE) && req_start && (req_len != 8'd0);
    reject    = (state == IDLE) && req_start && (req_len == 8'd0);
    hs        = (state == FETCH) && wr_valid && wr_ready;

    if (in_apb) begin
      case (phase)
        PH_GAP:    if (gap_cnt == '0) phase_nxt = PH_SETUP;
                   else gap_nxt = gap_cnt - GAP_W'(1);
        PH_SETUP:  phase_nxt = PH_ACCESS;
        PH_ACCESS: if (abort) begin
                     state_nxt = IDLE;
                     phase_nxt = PH_GAP;
                     gap_nxt   = '0;
                   end
        default:   phase_nxt = PH_GAP;
      endcase
    end

    if (acc_done) begin
      phase_nxt = PH_GAP;
      gap_nxt   = '0;
      case (state)
        W_PRE:     state_nxt = W_SADDR;
        W_SADDR:   state_nxt = FETCH;
        RD_STAT:   if (PRDATA[STAT_FULL_BIT]) gap_nxt = RETRY_GAP;
                   else state_nxt = W_TX;
        W_TX:      if (sent_inc == 8'd1)         state_nxt = W_CMD;
                   else if (sent_inc == lat_len) state_nxt = POLL_BUSY;
                   else                          state_nxt = FETCH;
        W_CMD:     state_nxt = (lat_len == 8'd1) ? POLL_BUSY : FETCH;
        POLL_BUSY: if (PRDATA[STAT_BUSY_BIT]) gap_nxt = RETRY_GAP;
                   else state_nxt = FINISH;
        default:   ;
      endcase
    end

    case (state)
      IDLE:    if (accept) begin
                 state_nxt = W_PRE;
                 phase_nxt = PH_GAP;
                 gap_nxt   = '0;
               end
      FETCH:   if (hs) begin
                 state_nxt = RD_STAT;
                 phase_nxt = PH_SETUP;
               end
      FINISH:  state_nxt = IDLE;
      default: ;
    endcase
  end

  // Output decode from the next state so every port comes from a flop
  always_comb begin
    psel_nxt     = 1'b0;
    penable_nxt  = 1'b0;
    pwrite_nxt   = PWRITE;
    paddr_nxt    = PADDR;
    pwdata_nxt   = PWDATA;
    wr_ready_nxt = (state_nxt == FETCH);
    busy_nxt     = (state_nxt != IDLE) && (state_nxt != FINISH);
    done_nxt     = (state_nxt == FINISH);
    err_nxt      = abort || reject;
    if (is_apb_state(state_nxt) && (phase_nxt != PH_GAP)) begin
      psel_nxt    = 1'b1;
      penable_nxt = (phase_nxt == PH_ACCESS);
    end
    if (is_apb_state(state_nxt) && (phase_nxt == PH_SETUP)) begin
      case (state_nxt)
        W_PRE:   begin pwrite_nxt = 1'b1; paddr_nxt = ADDR_PRESCALE; pwdata_nxt = lat_pre;   end
        W_SADDR: begin pwrite_nxt = 1'b1; paddr_nxt = ADDR_SLAVE;    pwdata_nxt = lat_addr;  end
        W_TX:    begin pwrite_nxt = 1'b1; paddr_nxt = ADDR_TX;       pwdata_nxt = lat_data;  end
        W_CMD:   begin pwrite_nxt = 1'b1; paddr_nxt = ADDR_CMD;      pwdata_nxt = CMD_WRITE; end
        default: begin pwrite_nxt = 1'b0; paddr_nxt = ADDR_STATUS;   pwdata_nxt = 8'd0;      end
      endcase
    end
  end

  // Output registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PSELx    <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= 8'd0;
      PWDATA   <= 8'd0;
      wr_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      PSELx    <= psel_nxt;
      PENABLE  <= penable_nxt;
      PWRITE   <= pwrite_nxt;
      PADDR    <= paddr_nxt;
      PWDATA   <= pwdata_nxt;
      wr_ready <= wr_ready_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

  // Request latches, byte counter and ACCESS timeout counter
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      lat_pre    <= 8'd0;
      lat_addr   <= 8'd0;
      lat_len    <= 8'd0;
      lat_data   <= 8'd0;
      bytes_sent <= 8'd0;
      to_cnt     <= '0;
    end else begin
      if (accept) begin
        lat_pre    <= req_prescale;
        lat_addr   <= req_addr;
        lat_len    <= req_len;
        bytes_sent <= 8'd0;
      end
      if (hs) lat_data <= wr_data;
      if (acc_done && (state == W_TX)) bytes_sent <= sent_inc;
      if (phase == PH_SETUP)       to_cnt <= '0;
      else if (phase == PH_ACCESS) to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// Randomized bench: APB slave model with scripted status reads, byte feeder
// with stalls, and an expected-transaction list built from the request.
module tb_i2c_apb_sequencer;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       req_start;
  logic [7:0] req_prescale, req_addr, req_len;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic       PSELx, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA;
  logic       PREADY;
  logic       busy, done, err;
  logic [7:0] bytes_sent;

  i2c_apb_sequencer dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_start(req_start),
    .req_prescale(req_prescale), .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .busy(busy),
    .done(done), .err(err), .bytes_sent(bytes_sent)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    bit       w;
    bit [7:0] a;
    bit [7:0] d;
    int       gap;
    bit       stable;
  } txn_t;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  txn_t     obs_q[$];
  txn_t     exp_q[$];
  bit [7:0] stat_q[$];
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, hs_cnt = 0, overlap_cnt = 0, acc2_cnt = 0;
  int max_wait = 0;
  bit to_armed = 0;
  int wait_left = 0;
  logic [7:0] prdata_r = 8'd0;
  int idle_run = 0;
  txn_t cur;

  assign PREADY = (wait_left == 0);
  assign PRDATA = prdata_r;

  // APB slave model and bus monitor
  always @(posedge PCLK) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if (wr_valid && wr_ready) hs_cnt++;
    if (wr_ready && PSELx) overlap_cnt++;
    if (PSELx && !PENABLE) begin
      cur.w = PWRITE; cur.a = PADDR; cur.d = PWRITE ? PWDATA : 8'd0;
      cur.gap = idle_run; cur.stable = 1'b1;
      idle_run = 0;
      if (to_armed && PADDR == 8'd2) begin
        wait_left <= 70;
        to_armed = 1'b0;
      end else begin
        wait_left <= (max_wait == 0) ? 0 : int'($urandom_range(0, max_wait));
      end
      if (!PWRITE) prdata_r <= (stat_q.size() != 0) ? stat_q.pop_front() : 8'h00;
    end else if (PSELx && PENABLE) begin
      if (PADDR != cur.a || PWRITE != cur.w || (PWRITE && PWDATA != cur.d)) cur.stable = 1'b0;
      if (PADDR == 8'd2) acc2_cnt++;
      if (PREADY) obs_q.push_back(cur);
      else if (wait_left > 0) wait_left <= wait_left - 1;
    end else begin
      idle_run++;
    end
  end

  // Byte feeder with random stalls and an optional long stall
  bit [7:0] feed_b[256];
  int  feed_n = 0, feed_base = 0, stall_at = -1, stall_len = 0, last_k = -1;
  bit  extra_en = 1'b0;
  initial begin
    int k;
    int stall_left;
    stall_left = 0;
    wr_valid = 1'b0;
    wr_data  = 8'd0;
    forever begin
      @(posedge PCLK); #1;
      k = hs_cnt - feed_base;
      if (k != last_k) begin
        last_k = k;
        stall_left = (k == stall_at) ? stall_len : int'($urandom_range(0, 2));
      end
      if (k < feed_n) begin
        if (stall_left > 0) begin
          wr_valid = 1'b0;
          stall_left--;
        end else begin
          wr_valid = 1'b1;
          wr_data  = feed_b[k];
        end
      end else if (extra_en) begin
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
      end else begin
        wr_valid = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge PCLK); #1; end
  endtask

  function automatic txn_t mk(input bit w, input bit [7:0] a, input bit [7:0] d, input int gap);
    txn_t t;
    t.w = w; t.a = a; t.d = d; t.gap = gap; t.stable = 1'b1;
    return t;
  endfunction

  task automatic arm_feeder(input int n, input int st_at, input int st_len);
    feed_base = hs_cnt;
    last_k    = -1;
    stall_at  = st_at;
    stall_len = st_len;
    feed_n    = n;
  endtask

  // One full request: build expectations, run, compare
  task automatic do_request(input bit [7:0] p, input bit [7:0] a, input int n, input bit seq,
                            input int full_at, input int full_reps, input int busy_reps,
                            input int st_at, input int st_len);
    int d0, e0, h0, ov0, cyc, fr, m;
    bit [7:0] v;
    exp_q.delete(); obs_q.delete(); stat_q.delete();
    exp_q.push_back(mk(1'b1, 8'd1, p, 0));
    exp_q.push_back(mk(1'b1, 8'd2, a, 0));
    for (int i = 0; i < n; i++) begin
      feed_b[i] = seq ? 8'(i + 1) : 8'($urandom);
      fr = (i == full_at) ? full_reps : 0;
      for (int r = 0; r <= fr; r++) begin
        exp_q.push_back(mk(1'b0, 8'd3, 8'd0, (r > 0) ? 4 : 0));
        v = 8'($urandom);
        v[6] = (r < fr);
        stat_q.push_back(v);
      end
      exp_q.push_back(mk(1'b1, 8'd4, feed_b[i], 0));
      if (i == 0) exp_q.push_back(mk(1'b1, 8'd6, 8'h90, 0));
    end
    for (int r = 0; r <= busy_reps; r++) begin
      exp_q.push_back(mk(1'b0, 8'd3, 8'd0, (r > 0) ? 4 : 0));
      v = 8'($urandom);
      v[5] = (r < busy_reps);
      stat_q.push_back(v);
    end
    d0 = done_cnt; e0 = err_cnt; h0 = hs_cnt; ov0 = overlap_cnt;
    arm_feeder(n, st_at, st_len);
    extra_en = 1'b1;
    req_prescale = p; req_addr = a; req_len = 8'(n); req_start = 1'b1;
    tick(1);
    req_start = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    check("bytes_cleared", int'(bytes_sent), 0);
    cyc = 0;
    while (done_cnt == d0 && err_cnt == e0 && cyc < 20000) begin tick(1); cyc++; end
    check("req_completes", done_cnt - d0, 1);
    check("req_no_err", err_cnt - e0, 0);
    check("busy_low_at_end", int'(busy), 0);
    tick(3);
    extra_en = 1'b0;
    feed_n = 0;
    check("done_single_pulse", done_cnt - d0, 1);
    check("bytes_sent_final", int'(bytes_sent), n);
    check("bytes_consumed", hs_cnt - h0, n);
    check("no_apb_in_fetch", overlap_cnt - ov0, 0);
    check("txn_count", obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("txn%0d_w_addr_data", i), int'({obs_q[i].w, obs_q[i].a, obs_q[i].d}),
            int'({exp_q[i].w, exp_q[i].a, exp_q[i].d}));
      if (exp_q[i].gap == 4) check($sformatf("txn%0d_retry_gap", i), obs_q[i].gap, 4);
      else check($sformatf("txn%0d_idle_before", i), int'(obs_q[i].gap >= 1), 1);
      check($sformatf("txn%0d_stable", i), int'(obs_q[i].stable), 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_psel"},    int'(PSELx), 0);
    check({tag, "_penable"}, int'(PENABLE), 0);
    check({tag, "_pwrite"},  int'(PWRITE), 0);
    check({tag, "_paddr"},   int'(PADDR), 0);
    check({tag, "_pwdata"},  int'(PWDATA), 0);
    check({tag, "_wr_ready"}, int'(wr_ready), 0);
    check({tag, "_busy"},    int'(busy), 0);
    check({tag, "_done"},    int'(done), 0);
    check({tag, "_err"},     int'(err), 0);
    check({tag, "_bytes"},   int'(bytes_sent), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, a0, cyc, ps, n;
    PRESET = 1'b1; req_start = 1'b0;
    req_prescale = 8'd0; req_addr = 8'd0; req_len = 8'd0;
    tick(3);
    check_all_zero("reset");
    PRESET = 1'b0;
    tick(2);

    // Basic 8-byte write with PREADY always high
    max_wait = 0;
    do_request(8'd4, 8'h20, 8, 1'b1, -1, 0, 0, -1, 0);

    // Single byte: one command, no further fetch
    max_wait = 2;
    exp_q.delete();
    do_request(8'd9, 8'h42, 1, 1'b0, -1, 0, 0, -1, 0);

    // FIFO full three times before byte 3
    do_request(8'd3, 8'h50, 5, 1'b1, 2, 3, 1, -1, 0);

    // PREADY stuck low during slave-address write
    d0 = done_cnt; e0 = err_cnt; a0 = acc2_cnt;
    to_armed = 1'b1;
    stat_q.delete();
    arm_feeder(2, -1, 0);
    req_prescale = 8'd7; req_addr = 8'h30; req_len = 8'd2; req_start = 1'b1;
    tick(1);
    req_start = 1'b0;
    cyc = 0;
    while (err_cnt == e0 && cyc < 500) begin tick(1); cyc++; end
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_access_cycles", acc2_cnt - a0, 64);
    check("timeout_psel_dropped", int'(PSELx), 0);
    check("timeout_busy_low", int'(busy), 0);
    tick(3);
    check("timeout_no_done", done_cnt - d0, 0);
    check("timeout_err_single", err_cnt - e0, 1);
    feed_n = 0;
    do_request(8'd2, 8'h31, 3, 1'b0, -1, 0, 0, -1, 0);

    // Zero length request rejected
    e0 = err_cnt; ps = 0;
    req_len = 8'd0; req_start = 1'b1;
    tick(1);
    req_start = 1'b0;
    check("len0_err_pulse", int'(err), 1);
    check("len0_busy", int'(busy), 0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      ps += int'(PSELx) + int'(busy);
    end
    check("len0_err_count", err_cnt - e0, 1);
    check("len0_no_traffic", ps, 0);

    // Reset during a TX write access
    stat_q.delete();
    d0 = done_cnt;
    arm_feeder(4, -1, 0);
    req_prescale = 8'd5; req_addr = 8'h44; req_len = 8'd4; req_start = 1'b1;
    tick(1);
    req_start = 1'b0;
    cyc = 0;
    while (!(PSELx && PENABLE && PADDR == 8'd4 && bytes_sent != 8'd0) && cyc < 2000) begin
      tick(1); cyc++;
    end
    check("rst_reached_tx", int'(cyc < 2000), 1);
    PRESET = 1'b1;
    tick(1);
    check_all_zero("midrst");
    PRESET = 1'b0;
    feed_n = 0;
    tick(8);
    check("midrst_no_done", done_cnt - d0, 0);

    // Long wr_valid gap mid-stream
    max_wait = 1;
    do_request(8'd6, 8'h5A, 6, 1'b0, -1, 0, 0, 3, 50);

    // Randomized requests
    for (int t = 0; t < 10; t++) begin
      max_wait = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 20));
      do_request(8'($urandom), 8'($urandom), n, 1'b0, int'($urandom_range(0, n - 1)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, n)), int'($urandom_range(0, 12)));
    end

    check("never_done_and_err", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
